tdc_readout_seq: RTL
====================

# tdc_readout_seq

Readout sequencer that sits directly upstream of the TDC byte-select decoder. On a start request it walks the 5-bit readout address through the 24-byte TDC register map: FPGA ID, 5 version bytes, priority-encoder byte, 16 counter bytes, DAC byte. It drives that address into the decoder and captures the byte returned by the downstream byte mux each cycle. It then presents the bytes as a framed valid/ready byte stream to the host-interface stage.

## Interface
Parameters:
- NUM_BYTES, 24, bytes per frame from the register map (addresses 0..NUM_BYTES-1)
- IDLE_ADDR, 31, address driven while not reading; decodes to no select

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  asynchronous, active-high reset
- start  in  1  frame request, sampled only in IDLE
- data_in  in  8  byte from downstream mux, combinationally selected by addr
- out_ready  in  1  consumer accepts byte_out this cycle
- addr  out  5  registered readout address to gen_sel_signals
- byte_out  out  8  registered output byte
- byte_valid  out  1  byte_out holds an unaccepted byte
- byte_sof  out  1  qualifies byte_out as first byte of frame
- byte_eof  out  1  qualifies byte_out as last byte of frame
- busy  out  1  frame in progress
- frame_done  out  1  one-cycle pulse after the last byte is accepted

## Operation
- States: IDLE, RUN, CSUM (macro only), DRAIN.
- IDLE:
  - addr = IDLE_ADDR.
  - start=1 moves to RUN with addr=0 and clears the checksum accumulator.
- RUN:
  - The slot is free when byte_valid=0, or when byte_valid=1 and out_ready=1.
  - When the slot is free: load byte_out with data_in, set byte_valid, and set sof when addr==0.
  - In the same cycle, advance addr by 1.
  - When addr==NUM_BYTES-1 is captured:
    - Without the macro: set eof, set addr=IDLE_ADDR, go to DRAIN.
    - With the macro: set addr=IDLE_ADDR, go to CSUM.
  - When the slot is not free, hold addr, byte_out and the flags.
- CSUM: when the slot is free, load the checksum byte with eof=1 and go to DRAIN.
- DRAIN:
  - When the held byte is accepted: clear byte_valid, pulse frame_done, go to IDLE.
- Handshake: a byte transfers on any cycle with byte_valid & out_ready. byte_out, sof and eof stay stable while byte_valid=1 and out_ready=0.
- Boundary conditions:
  - start outside IDLE is ignored, with no queueing.
  - start in the same cycle as frame_done is accepted, because the block is already in IDLE.
  - addr never wraps. The address after NUM_BYTES-1 is always IDLE_ADDR.
  - rst at any time aborts the frame. The partial frame is lost with no eof.
- Reset values:
  - addr=IDLE_ADDR.
  - byte_out=0x00.
  - byte_valid, byte_sof, byte_eof, busy and frame_done all 0.
  - State IDLE, checksum 0x00.

## Timing
- Edge E0 samples start: addr=0 after E0, busy=1.
- Edge Ek (k=1..24) with out_ready held high:
  - captures the byte at address k-1 and sets addr=k.
  - At E24, addr goes to IDLE_ADDR instead of 24.
- Capture-to-output latency is 1 cycle. data_in must be valid in the same cycle addr is driven.
- With out_ready=1 throughout and no macro:
  - The last byte is accepted at E25.
  - frame_done=1 and busy=0 for one cycle after E25.
  - Start to frame_done takes 25 cycles; each additional stall cycle adds exactly one cycle.
- With the macro: the checksum byte is loaded at E25 and accepted at E26. frame_done follows E26.
- Throughput is one byte per cycle under continuous ready.

## Configuration
- READOUT_CHECKSUM_EN:
  - When defined, each frame carries NUM_BYTES+1 bytes. The final byte is the 8-bit XOR of all NUM_BYTES data bytes.
  - eof moves to the checksum byte, and the CSUM state exists.
  - When undefined, frames carry NUM_BYTES bytes, eof is on the address NUM_BYTES-1 byte, and no accumulator is built.

## Structure
- Shared package tdc_readout_pkg holds:
  - address-map constants: ADDR_FPGA=0, ADDR_VER_BASE=1, ADDR_PENC=6, ADDR_CNTR_BASE=7, ADDR_DAC=23, ADDR_LAST=23, ADDR_IDLE=31;
  - NUM_BYTES=24;
  - the sequencer state enum.
- One sub-module: tdc_readout_obuf, a one-entry output register with the valid/ready logic. It carries byte_out, sof and eof and produces the "slot free" signal.

## Test plan
- Reset check: assert rst mid-simulation with random inputs, then release.
  - Expect addr=31, byte_valid=0, busy=0, frame_done=0 immediately (asynchronous) and after release.
- Streaming frame, no macro: data_in = 0xA0+addr, out_ready=1, start pulse.
  - Expect bytes 0xA0..0xB7 on 24 consecutive cycles, sof on 0xA0, eof on 0xB7.
  - Expect frame_done 25 cycles after the start edge, then addr=31.
- Backpressure: drop out_ready for 5 cycles while byte_out=0xAA.
  - Expect 0xAA, sof/eof and addr=11 held stable throughout.
  - Expect no byte lost or duplicated, and frame_done delayed by exactly 5 cycles.
- start handling: pulse start at byte 7 of a frame, and again on the frame_done cycle.
  - Expect the first pulse ignored, and a second full frame starting with addr=0 one cycle after frame_done.
- Abort: assert rst while addr=15, then release and pulse start.
  - Expect no eof from the aborted frame, and the new frame beginning at addr=0 with sof.
- Checksum (READOUT_CHECKSUM_EN): data_in=0x01 for addresses 0..22, 0x80 for address 23.
  - Expect a 25th byte of 0x81 with eof=1, and frame_done 26 cycles after the start edge.

Source files
------------

// File: rtl/tdc_readout_pkg.sv
// Shared address map, frame length and sequencer state encoding for the TDC readout path.
// READOUT_CHECKSUM_EN adds the checksum state.
package tdc_readout_pkg;

   localparam int         NUM_BYTES      = 24;
   localparam logic [4:0] ADDR_FPGA      = 5'd0;
   localparam logic [4:0] ADDR_VER_BASE  = 5'd1;
   localparam logic [4:0] ADDR_PENC      = 5'd6;
   localparam logic [4:0] ADDR_CNTR_BASE = 5'd7;
   localparam logic [4:0] ADDR_DAC       = 5'd23;
   localparam logic [4:0] ADDR_LAST      = 5'd23;
   localparam logic [4:0] ADDR_IDLE      = 5'd31;

   typedef enum logic [1:0] {
      S_IDLE,
      S_RUN,
`ifdef READOUT_CHECKSUM_EN
      S_CSUM,
`endif
      S_DRAIN
   } seq_state_t;

endpackage

// File: rtl/tdc_readout_obuf.sv
// One-entry registered byte slot with sof/eof tags; 1-cycle load-to-output latency.
// Holds its contents while valid and not ready; free_o means a load may happen this cycle.
module tdc_readout_obuf (
   input  logic       clk,
   input  logic       rst,
   input  logic       load_i,
   input  logic [7:0] dat_i,
   input  logic       sof_i,
   input  logic       eof_i,
   input  logic       rdy_i,
   output logic       vld_o,
   output logic [7:0] dat_o,
   output logic       sof_o,
   output logic       eof_o,
   output logic       free_o
);

   logic       vld_q;
   logic [7:0] dat_q;
   logic       sof_q;
   logic       eof_q;

   // A held byte leaving this cycle frees the slot for a same-cycle refill.
   assign free_o = ~vld_q | rdy_i;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         vld_q <= 1'b0;
         dat_q <= 8'h00;
         sof_q <= 1'b0;
         eof_q <= 1'b0;
      end else if (load_i) begin
         vld_q <= 1'b1;
         dat_q <= dat_i;
         sof_q <= sof_i;
         eof_q <= eof_i;
      end else if (vld_q && rdy_i) begin
         vld_q <= 1'b0;
      end
   end

   assign vld_o = vld_q;
   assign dat_o = dat_q;
   assign sof_o = sof_q;
   assign eof_o = eof_q;

endmodule

// File: rtl/tdc_readout_seq.sv
// Walks the TDC register map and streams the captured bytes as a framed valid/ready stream.
// 1-cycle capture-to-output; stalls address and slot under backpressure. READOUT_CHECKSUM_EN appends an XOR byte.
module tdc_readout_seq #(
   parameter int         NUM_BYTES = 24,
   parameter logic [4:0] IDLE_ADDR = 5'd31
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic [7:0] data_in,
   input  logic       out_ready,
   output logic [4:0] addr,
   output logic [7:0] byte_out,
   output logic       byte_valid,
   output logic       byte_sof,
   output logic       byte_eof,
   output logic       busy,
   output logic       frame_done
);
   import tdc_readout_pkg::*;

   localparam logic [4:0] LAST_ADDR = 5'(NUM_BYTES - 1);

   seq_state_t state_q, state_d;
   logic [4:0] addr_q, addr_d;
   logic       frame_done_q, frame_done_d;
   logic       slot_free;
   logic       ld_vld;
   logic [7:0] ld_dat;
   logic       ld_sof;
   logic       ld_eof;
`ifdef READOUT_CHECKSUM_EN
   logic [7:0] csum_q, csum_d;
`endif

   always_comb begin
      state_d      = state_q;
      addr_d       = addr_q;
      frame_done_d = 1'b0;
      ld_vld       = 1'b0;
      ld_dat       = data_in;
      ld_sof       = 1'b0;
      ld_eof       = 1'b0;
`ifdef READOUT_CHECKSUM_EN
      csum_d       = csum_q;
`endif
      case (state_q)
         S_IDLE: begin
            addr_d = IDLE_ADDR;
            if (start) begin
               state_d = S_RUN;
               addr_d  = ADDR_FPGA;
`ifdef READOUT_CHECKSUM_EN
               csum_d  = 8'h00;
`endif
            end
         end
         S_RUN: begin
            if (slot_free) begin
               ld_vld = 1'b1;
               ld_sof = (addr_q == ADDR_FPGA);
`ifdef READOUT_CHECKSUM_EN
               csum_d = csum_q ^ data_in;
`endif
               if (addr_q == LAST_ADDR) begin
                  // Never step past the map: park on the no-select address.
                  addr_d = IDLE_ADDR;
`ifdef READOUT_CHECKSUM_EN
                  state_d = S_CSUM;
`else
                  ld_eof  = 1'b1;
                  state_d = S_DRAIN;
`endif
               end else begin
                  addr_d = addr_q + 5'd1;
               end
            end
         end
`ifdef READOUT_CHECKSUM_EN
         S_CSUM: begin
            if (slot_free) begin
               ld_vld  = 1'b1;
               ld_dat  = csum_q;
               ld_eof  = 1'b1;
               state_d = S_DRAIN;
            end
         end
`endif
         S_DRAIN: begin
            if (byte_valid && out_ready) begin
               frame_done_d = 1'b1;
               state_d      = S_IDLE;
            end
         end
         default: begin
            state_d = S_IDLE;
            addr_d  = IDLE_ADDR;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= S_IDLE;
         addr_q       <= IDLE_ADDR;
         frame_done_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         addr_q       <= addr_d;
         frame_done_q <= frame_done_d;
      end
   end

`ifdef READOUT_CHECKSUM_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) csum_q <= 8'h00;
      else     csum_q <= csum_d;
   end
`endif

   tdc_readout_obuf u_obuf (
      .clk    (clk),
      .rst    (rst),
      .load_i (ld_vld),
      .dat_i  (ld_dat),
      .sof_i  (ld_sof),
      .eof_i  (ld_eof),
      .rdy_i  (out_ready),
      .vld_o  (byte_valid),
      .dat_o  (byte_out),
      .sof_o  (byte_sof),
      .eof_o  (byte_eof),
      .free_o (slot_free)
   );

   assign addr       = addr_q;
   assign busy       = (state_q != S_IDLE);
   assign frame_done = frame_done_q;

endmodule
